// File: rtl/rx_hdr_parse_pkg.sv
// Shared constants and state encoding for the receive header parser.
package rx_hdr_parse_pkg;

    localparam logic [7:0] ACK_TYPE  = 8'h32;
    localparam logic [7:0] PASS_TYPE = 8'h51;

    // Byte offsets of the header fields inside the receive buffer
    localparam logic [7:0] HDR_ID_OFS   = 8'd0;
    localparam logic [7:0] HDR_TYPE_OFS = 8'd1;
    localparam logic [7:0] HDR_SN_OFS   = 8'd2;

    localparam int NUM_IDS_DEFAULT = 72;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_RD1   = 3'd2,
        ST_RD2   = 3'd3,
        ST_LATCH = 3'd4,
        ST_TBL   = 3'd5,
        ST_CHK   = 3'd6
    } parse_state_t;

endpackage

// File: rtl/rx_sn_table.sv
// Per-id sequence-number store: synchronous RAM plus valid bits.
module rx_sn_table #(
    parameter int NUM_IDS = 72,
    parameter int AW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data
);

    logic [7:0]         mem [NUM_IDS];
    logic [NUM_IDS-1:0] valid;

    // RAM contents are never reset; the valid bits make stale data harmless
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Valid bits set on any write, cleared only by reset; read alongside the RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                valid[wr_addr] <= 1'b1;
            end
            if (rd_en) begin
                rd_valid <= valid[rd_addr];
            end
        end
    end

endmodule

// File: rtl/rx_hdr_parse.sv
// Reads the 3-byte frame header from the receive buffer and checks the
// per-id sequence number against the last accepted one.
module rx_hdr_parse
    import rx_hdr_parse_pkg::*;
#(
    parameter int NUM_IDS = NUM_IDS_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       glbl_rst,
    input  logic       load_rd_en,
    output logic       rxbuf_rd_en,
    output logic [7:0] rxbuf_rd_addr,
    input  logic [7:0] rxbuf_rd_data,
    output logic       got_frame,
    output logic [7:0] frame_id,
    output logic [7:0] frame_type,
    output logic       sn_error,
    output logic       busy
);

    localparam int         AW       = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
    localparam logic [8:0] ID_LIMIT = 9'(NUM_IDS);

    parse_state_t state;
    parse_state_t next_state;

    logic [7:0] sn;
    logic       in_range;
    logic       tbl_rd_en;
    logic       tbl_wr_en;
    logic [7:0] tbl_data;
    logic       tbl_valid;
    logic [7:0] expected_sn;
    logic       sn_ok;

    assign in_range    = ({1'b0, frame_id} < ID_LIMIT);
    assign expected_sn = tbl_data + 8'd1;
    assign sn_ok       = !tbl_valid || (sn == expected_sn);
    assign tbl_rd_en   = (state == ST_TBL) && in_range;
    assign tbl_wr_en   = (state == ST_CHK) && in_range && sn_ok;

    rx_sn_table #(
        .NUM_IDS (NUM_IDS),
        .AW      (AW)
    ) u_sn_table (
        .clk      (sys_clk),
        .rst      (glbl_rst),
        .rd_en    (tbl_rd_en),
        .rd_addr  (frame_id[AW-1:0]),
        .rd_data  (tbl_data),
        .rd_valid (tbl_valid),
        .wr_en    (tbl_wr_en),
        .wr_addr  (frame_id[AW-1:0]),
        .wr_data  (sn)
    );

    // State register
    always_ff @(posedge sys_clk or posedge glbl_rst) begin
        if (glbl_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fixed walk through the parse; only IDLE waits for a request
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (load_rd_en) next_state = ST_RD0;
            ST_RD0:   next_state = ST_RD1;
            ST_RD1:   next_state = ST_RD2;
            ST_RD2:   next_state = ST_LATCH;
            ST_LATCH: next_state = ST_TBL;
            ST_TBL:   next_state = ST_CHK;
            ST_CHK:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one leaves a flop
    always_ff @(posedge sys_clk or posedge glbl_rst) begin
        if (glbl_rst) begin
            busy          <= 1'b0;
            got_frame     <= 1'b0;
            sn_error      <= 1'b0;
            rxbuf_rd_en   <= 1'b0;
            rxbuf_rd_addr <= 8'd0;
            frame_id      <= 8'd0;
            frame_type    <= 8'd0;
            sn            <= 8'd0;
        end else begin
            busy        <= (next_state != ST_IDLE);
            got_frame   <= (next_state == ST_TBL);
            sn_error    <= (state == ST_CHK) && in_range && !sn_ok;
            rxbuf_rd_en <= (next_state == ST_RD0) || (next_state == ST_RD1) ||
                           (next_state == ST_RD2);
            case (next_state)
                ST_RD0:  rxbuf_rd_addr <= HDR_ID_OFS;
                ST_RD1:  rxbuf_rd_addr <= HDR_TYPE_OFS;
                ST_RD2:  rxbuf_rd_addr <= HDR_SN_OFS;
                default: rxbuf_rd_addr <= 8'd0;
            endcase
            if (state == ST_RD1) begin
                frame_id <= rxbuf_rd_data;
            end
            if (state == ST_RD2) begin
                frame_type <= rxbuf_rd_data;
            end
            if (state == ST_LATCH) begin
                sn <= rxbuf_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_rx_hdr_parse.sv
// Randomized and directed bench for rx_hdr_parse with a per-id sequence model.
module tb_rx_hdr_parse;

    logic       sys_clk = 1'b0;
    logic       glbl_rst;
    logic       load_rd_en;
    logic       rxbuf_rd_en;
    logic [7:0] rxbuf_rd_addr;
    logic [7:0] rxbuf_rd_data;
    logic       got_frame;
    logic [7:0] frame_id;
    logic [7:0] frame_type;
    logic       sn_error;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int frame_no     = 0;

    logic [7:0] buf_mem [0:255];
    logic       ref_valid [0:255];
    logic [7:0] ref_sn [0:255];

    rx_hdr_parse dut (
        .sys_clk       (sys_clk),
        .glbl_rst      (glbl_rst),
        .load_rd_en    (load_rd_en),
        .rxbuf_rd_en   (rxbuf_rd_en),
        .rxbuf_rd_addr (rxbuf_rd_addr),
        .rxbuf_rd_data (rxbuf_rd_data),
        .got_frame     (got_frame),
        .frame_id      (frame_id),
        .frame_type    (frame_type),
        .sn_error      (sn_error),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Receive buffer with one cycle of read latency
    always @(posedge sys_clk) begin
        if (rxbuf_rd_en) begin
            rxbuf_rd_data <= buf_mem[rxbuf_rd_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // Reference rule: first frame per id accepted, then only last+1 (mod 256)
    task automatic modelFrame(input logic [7:0] id, input logic [7:0] sn, output logic err);
        err = 1'b0;
        if (int'(id) < 72) begin
            if (!ref_valid[id]) begin
                ref_valid[id] = 1'b1;
                ref_sn[id]    = sn;
            end else if (sn == 8'(ref_sn[id] + 8'd1)) begin
                ref_sn[id] = sn;
            end else begin
                err = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] id, input logic [7:0] typ,
                                 input logic [7:0] sn, input int extra_at);
        logic        exp_err;
        logic [15:0] rd_mask, gf_mask, err_mask, busy_mask;
        logic [23:0] addrs;
        logic [7:0]  id_seen, type_seen;
        modelFrame(id, sn, exp_err);
        buf_mem[0] = id;
        buf_mem[1] = typ;
        buf_mem[2] = sn;
        rd_mask = '0; gf_mask = '0; err_mask = '0; busy_mask = '0;
        addrs = '0; id_seen = '0; type_seen = '0;
        frame_no++;
        @(negedge sys_clk);
        load_rd_en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge sys_clk);
            load_rd_en   = (c == extra_at);
            rd_mask[c]   = rxbuf_rd_en;
            gf_mask[c]   = got_frame;
            err_mask[c]  = sn_error;
            busy_mask[c] = busy;
            if (rxbuf_rd_en) addrs = {addrs[15:0], rxbuf_rd_addr};
            if (got_frame) begin
                id_seen   = frame_id;
                type_seen = frame_type;
            end
        end
        checkOutput($sformatf("f%0d rd_en_cycles", frame_no), 32'(rd_mask), 32'h000E);
        checkOutput($sformatf("f%0d rd_addrs", frame_no), 32'(addrs), 32'h000102);
        checkOutput($sformatf("f%0d got_frame_cycles", frame_no), 32'(gf_mask), 32'h0020);
        checkOutput($sformatf("f%0d sn_error_cycles", frame_no), 32'(err_mask),
                    exp_err ? 32'h0080 : 32'h0000);
        checkOutput($sformatf("f%0d busy_cycles", frame_no), 32'(busy_mask), 32'h007E);
        checkOutput($sformatf("f%0d frame_id", frame_no), 32'(id_seen), 32'(id));
        checkOutput($sformatf("f%0d frame_type", frame_no), 32'(type_seen), 32'(typ));
    endtask

    // Abort a parse with reset three cycles after the request
    task automatic resetMidParse();
        int pulses;
        pulses = 0;
        buf_mem[0] = 8'h05;
        buf_mem[1] = 8'h32;
        buf_mem[2] = 8'h77;
        @(negedge sys_clk);
        load_rd_en = 1'b1;
        @(negedge sys_clk);
        load_rd_en = 1'b0;
        pulses += int'(got_frame) + int'(sn_error);
        @(negedge sys_clk);
        pulses += int'(got_frame) + int'(sn_error);
        @(negedge sys_clk);
        glbl_rst = 1'b1;
        #1;
        checkOutput("rst_mid busy", 32'(busy), 32'h0);
        checkOutput("rst_mid frame_id", 32'(frame_id), 32'h0);
        checkOutput("rst_mid rd_en", 32'(rxbuf_rd_en), 32'h0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge sys_clk);
            if (c == 2) glbl_rst = 1'b0;
            pulses += int'(got_frame) + int'(sn_error);
        end
        checkOutput("rst_mid pulses", 32'(pulses), 32'h0);
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    endtask

    initial begin
        int        pick, mode;
        logic [7:0] rid, rsn;
        logic [7:0] id_pool [10];
        id_pool = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h07, 8'h00, 8'h47, 8'h48, 8'h64, 8'hFF};
        for (int i = 0; i < 256; i++) begin
            buf_mem[i]   = 8'h00;
            ref_valid[i] = 1'b0;
            ref_sn[i]    = 8'h00;
        end
        rxbuf_rd_data = 8'h00;
        load_rd_en    = 1'b0;
        glbl_rst      = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        checkOutput("reset pulses_busy", 32'({got_frame, sn_error, busy, rxbuf_rd_en}), 32'h0);
        checkOutput("reset rd_addr", 32'(rxbuf_rd_addr), 32'h0);
        checkOutput("reset id_type", 32'({frame_id, frame_type}), 32'h0);
        glbl_rst = 1'b0;
        @(negedge sys_clk);

        applyStimulus(8'h05, 8'h32, 8'h10, 0);
        applyStimulus(8'h05, 8'h51, 8'h11, 0);
        applyStimulus(8'h05, 8'h51, 8'h11, 0);
        applyStimulus(8'h05, 8'h51, 8'h12, 0);
        applyStimulus(8'h07, 8'h51, 8'hFF, 0);
        applyStimulus(8'h07, 8'h51, 8'h00, 0);
        applyStimulus(8'h08, 8'h51, 8'hFF, 0);
        applyStimulus(8'h08, 8'h51, 8'h02, 0);
        applyStimulus(8'h47, 8'h32, 8'h33, 0);
        applyStimulus(8'h47, 8'h32, 8'h33, 0);
        applyStimulus(8'h48, 8'h32, 8'h33, 0);
        applyStimulus(8'h48, 8'h32, 8'h33, 0);
        applyStimulus(8'h05, 8'h32, 8'h13, 3);

        resetMidParse();
        applyStimulus(8'h05, 8'h32, 8'h20, 0);

        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 9));
            mode = int'($urandom_range(0, 2));
            rid  = id_pool[pick];
            case (mode)
                0:       rsn = 8'(ref_sn[rid] + 8'd1);
                1:       rsn = ref_sn[rid];
                default: rsn = 8'($urandom_range(0, 255));
            endcase
            applyStimulus(rid, 8'($urandom_range(0, 255)), rsn,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
